// File: rtl/fp_divider_if.sv
// Handshake and operand/result bundle for the iterative FP divider.
// The requester drives start and operands; the divider drives result,
// status and exception flags.
interface fp_divider_if;
  logic        start;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        over_flow;
  logic        under_flow;
  logic        div_by_zero;

  modport master (
    output start, inputA, inputB,
    input  result, busy, done, over_flow, under_flow, div_by_zero
  );

  modport slave (
    input  start, inputA, inputB,
    output result, busy, done, over_flow, under_flow, div_by_zero
  );
endinterface

// File: rtl/fp_divider.sv
// Iterative IEEE-754 single-precision divider.
// Radix-2 restoring mantissa division, one quotient bit per clock.
// Subnormals flush to zero, the quotient is truncated, and exponent 255
// is treated as infinity with no NaN distinction.
module fp_divider (
  input  logic         clk,
  input  logic         rst,
  fp_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  logic               sign_r;
  logic signed [9:0]  exp_r;
  logic [25:0]        rem_r;
  logic [23:0]        div_r;
  logic [24:0]        quo_r;
  logic [4:0]         cnt_r;

  logic [31:0]        result_r;
  logic               busy_r;
  logic               done_r;
  logic               over_flow_r;
  logic               under_flow_r;
  logic               div_by_zero_r;

  // Operand fields
  logic [7:0]         a_exp;
  logic [7:0]         b_exp;
  logic               in_sign;

  assign a_exp   = bus.inputA[30:23];
  assign b_exp   = bus.inputB[30:23];
  assign in_sign = bus.inputA[31] ^ bus.inputB[31];

  // Datapath helpers: capture exponent, trial subtraction, normalisation
  logic signed [9:0]  cap_exp;
  logic               rem_ge;
  logic [25:0]        rem_diff;
  logic signed [9:0]  norm_exp;
  logic [22:0]        norm_mant;

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    cap_exp   = '0;
    rem_ge    = 1'b0;
    rem_diff  = '0;
    norm_exp  = '0;
    norm_mant = '0;

    cap_exp  = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
    rem_ge   = (rem_r >= {2'b00, div_r});
    rem_diff = rem_r - {2'b00, div_r};

    // The mantissa ratio lies in (0.5, 2): at most one left shift needed.
    if (quo_r[24]) begin
      norm_exp  = exp_r;
      norm_mant = quo_r[23:1];
    end else begin
      norm_exp  = exp_r - 10'sd1;
      norm_mant = quo_r[22:0];
    end
  end

  // Control FSM plus all datapath and output registers
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sign_r        <= 1'b0;
      exp_r         <= '0;
      rem_r         <= '0;
      div_r         <= '0;
      quo_r         <= '0;
      cnt_r         <= '0;
      result_r      <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      over_flow_r   <= 1'b0;
      under_flow_r  <= 1'b0;
      div_by_zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_r        <= in_sign;
            over_flow_r   <= 1'b0;
            under_flow_r  <= 1'b0;
            div_by_zero_r <= 1'b0;
            if (b_exp == 8'd0) begin
              result_r      <= {in_sign, 8'hFF, 23'h0};
              div_by_zero_r <= 1'b1;
              done_r        <= 1'b1;
              state         <= DONE;
            end else if (a_exp == 8'hFF) begin
              result_r    <= {in_sign, 8'hFF, 23'h0};
              over_flow_r <= 1'b1;
              done_r      <= 1'b1;
              state       <= DONE;
            end else if (a_exp == 8'd0) begin
              result_r <= {in_sign, 31'h0};
              done_r   <= 1'b1;
              state    <= DONE;
            end else if (b_exp == 8'hFF) begin
              result_r     <= {in_sign, 31'h0};
              under_flow_r <= 1'b1;
              done_r       <= 1'b1;
              state        <= DONE;
            end else begin
              exp_r  <= cap_exp;
              rem_r  <= {2'b01, bus.inputA[22:0]};
              div_r  <= {1'b1, bus.inputB[22:0]};
              quo_r  <= '0;
              cnt_r  <= '0;
              busy_r <= 1'b1;
              state  <= DIVIDE;
            end
          end
        end

        DIVIDE: begin
          if (rem_ge) begin
            rem_r <= {rem_diff[24:0], 1'b0};
            quo_r <= {quo_r[23:0], 1'b1};
          end else begin
            rem_r <= {rem_r[24:0], 1'b0};
            quo_r <= {quo_r[23:0], 1'b0};
          end
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd24) begin
            state <= NORM;
          end
        end

        NORM: begin
          if (norm_exp >= 10'sd255) begin
            result_r    <= {sign_r, 8'hFF, 23'h0};
            over_flow_r <= 1'b1;
          end else if (norm_exp <= 10'sd0) begin
            result_r     <= {sign_r, 31'h0};
            under_flow_r <= 1'b1;
          end else begin
            result_r <= {sign_r, norm_exp[7:0], norm_mant};
          end
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= DONE;
        end

        DONE: begin
          // start is deliberately ignored here; it is not queued.
          done_r <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.result      = result_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.over_flow   = over_flow_r;
  assign bus.under_flow  = under_flow_r;
  assign bus.div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: scoreboard of expected quotients
// and flags, pushed at request time and popped when done is seen.
module tb_fp_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fp_divider_if ifc ();

  fp_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // flags packed as {over_flow, under_flow, div_by_zero}
  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb[$];

  function automatic logic [2:0] flags_now();
    return {ifc.over_flow, ifc.under_flow, ifc.div_by_zero};
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    e.res   = 'x;
    e.flags = 'x;
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single accepting edge and record its expectation
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic [2:0] f);
    exp_t e;
    e.res   = r;
    e.flags = f;
    sb.push_back(e);
    ifc.inputA = a;
    ifc.inputB = b;
    ifc.start  = 1'b1;
    tick();
    ifc.start  = 1'b0;
  endtask

  // Bounded wait for done; cycles counts from the cycle start was raised
  task automatic wait_done(input int c0, output int cycles, output int busy_cnt);
    cycles   = c0;
    busy_cnt = 0;
    while (ifc.done !== 1'b1 && cycles < 200) begin
      if (ifc.busy === 1'b1) busy_cnt++;
      tick();
      cycles++;
    end
    checks++;
    if (ifc.done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", ifc.done, cycles);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    ifc.start  = 1'b0;
    ifc.inputA = '0;
    ifc.inputB = '0;
    repeat (3) tick();
    checks++;
    if (ifc.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: got %h, required 00000000", ifc.result);
    end
    checks++;
    if ({ifc.busy, ifc.done, flags_now()} !== 5'b0) begin
      errors++;
      $display("FAIL reset_status: busy,done,flags got %b, required 00000", {ifc.busy, ifc.done, flags_now()});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal();
    int   c, b;
    exp_t e;
    send(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000);
    wait_done(1, c, b);
    e = pop_exp();
    checks++;
    if (c !== 27) begin
      errors++;
      $display("FAIL normal_latency: done after %0d cycles, required 27", c);
    end
    checks++;
    if (b !== 26) begin
      errors++;
      $display("FAIL normal_busy: busy high %0d cycles, required 26", b);
    end
    checks++;
    if (ifc.result !== e.res || flags_now() !== e.flags) begin
      errors++;
      $display("FAIL normal_6div2: got %h flags %b, required %h flags %b", ifc.result, flags_now(), e.res, e.flags);
    end
    tick();
    checks++;
    if (ifc.done !== 1'b0 || ifc.result !== e.res) begin
      errors++;
      $display("FAIL done_pulse: done=%b result=%h, required done=0 result=%h", ifc.done, ifc.result, e.res);
    end
  endtask

  task automatic test_truncation();
    int   c, b;
    exp_t e;
    send(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000);
    wait_done(1, c, b);
    e = pop_exp();
    checks++;
    if (ifc.result !== e.res || flags_now() !== e.flags) begin
      errors++;
      $display("FAIL trunc_1div3: got %h flags %b, required %h flags %b", ifc.result, flags_now(), e.res, e.flags);
    end
    tick();
  endtask

  task automatic test_sign_and_norm();
    logic [31:0] a_tab [2] = '{32'hBFC00000, 32'h3F800000};
    logic [31:0] b_tab [2] = '{32'h3F000000, 32'h3F800000};
    logic [31:0] r_tab [2] = '{32'hC0400000, 32'h3F800000};
    int   c, b;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      send(a_tab[i], b_tab[i], r_tab[i], 3'b000);
      wait_done(1, c, b);
      e = pop_exp();
      checks++;
      if (ifc.result !== e.res || flags_now() !== e.flags || c !== 27) begin
        errors++;
        $display("FAIL sign_norm[%0d]: got %h flags %b lat %0d, required %h flags %b lat 27", i, ifc.result, flags_now(), c, e.res, e.flags);
      end
      tick();
    end
  endtask

  task automatic test_specials();
    // 1/0, inf dividend, exponent overflow, exponent underflow, 0/0, 0/2, 1/inf
    logic [31:0] a_tab [7] = '{32'h3F800000, 32'hFF800000, 32'h7F000000, 32'h00800000,
                               32'h00000000, 32'h00000000, 32'h3F800000};
    logic [31:0] b_tab [7] = '{32'h00000000, 32'h40000000, 32'h3E800000, 32'h40000000,
                               32'h00000000, 32'h40000000, 32'h7F800000};
    logic [31:0] r_tab [7] = '{32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h00000000,
                               32'h7F800000, 32'h00000000, 32'h00000000};
    logic [2:0]  f_tab [7] = '{3'b001, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010};
    int   l_tab [7] = '{1, 1, 27, 27, 1, 1, 1};
    int   c, b;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      send(a_tab[i], b_tab[i], r_tab[i], f_tab[i]);
      wait_done(1, c, b);
      e = pop_exp();
      checks++;
      if (ifc.result !== e.res || flags_now() !== e.flags || c !== l_tab[i]) begin
        errors++;
        $display("FAIL special[%0d]: got %h flags %b lat %0d, required %h flags %b lat %0d", i, ifc.result, flags_now(), c, e.res, e.flags, l_tab[i]);
      end
      if (i == 0) begin
        // start during DONE must be dropped, not queued
        ifc.inputA = 32'h40000000;
        ifc.inputB = 32'h00000000;
        ifc.start  = 1'b1;
        tick();
        ifc.start  = 1'b0;
        tick();
        checks++;
        if (ifc.done !== 1'b0 || ifc.busy !== 1'b0 || ifc.result !== e.res) begin
          errors++;
          $display("FAIL start_in_done: done=%b busy=%b result=%h, required 0 0 %h", ifc.done, ifc.busy, ifc.result, e.res);
        end
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_ignore_start();
    int   c, b;
    exp_t e;
    send(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000);
    repeat (3) tick();
    ifc.inputA = 32'h3F800000;
    ifc.inputB = 32'h40400000;
    ifc.start  = 1'b1;
    tick();
    ifc.start  = 1'b0;
    wait_done(5, c, b);
    e = pop_exp();
    checks++;
    if (ifc.result !== e.res || flags_now() !== e.flags || c !== 27) begin
      errors++;
      $display("FAIL ignore_start: got %h flags %b lat %0d, required %h flags %b lat 27", ifc.result, flags_now(), c, e.res, e.flags);
    end
    tick();
    tick();
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_not_queued: busy=%b done=%b, required 0 0", ifc.busy, ifc.done);
    end
  endtask

  task automatic test_reset_mid();
    int   c, b;
    bit   seen;
    exp_t e;
    ifc.inputA = 32'h40C00000;
    ifc.inputB = 32'h40000000;
    ifc.start  = 1'b1;
    tick();
    ifc.start  = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ifc.result, ifc.busy, ifc.done, flags_now()} !== 37'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: result=%h busy=%b done=%b flags=%b, required all 0", ifc.result, ifc.busy, ifc.done, flags_now());
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ifc.done === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: done pulse seen=%b, required 0", seen);
    end
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);
    wait_done(1, c, b);
    e = pop_exp();
    checks++;
    if (ifc.result !== e.res || flags_now() !== e.flags || c !== 27) begin
      errors++;
      $display("FAIL after_reset_1div1: got %h flags %b lat %0d, required %h flags %b lat 27", ifc.result, flags_now(), c, e.res, e.flags);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int   c, b;
    exp_t e;
    send(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000);
    wait_done(1, c, b);
    e = pop_exp();
    checks++;
    if (ifc.result !== e.res || flags_now() !== e.flags) begin
      errors++;
      $display("FAIL b2b_first: got %h flags %b, required %h flags %b", ifc.result, flags_now(), e.res, e.flags);
    end
    tick();
    send(32'hBFC00000, 32'h3F000000, 32'hC0400000, 3'b000);
    wait_done(1, c, b);
    e = pop_exp();
    checks++;
    if (ifc.result !== e.res || flags_now() !== e.flags || c !== 27 || b !== 26) begin
      errors++;
      $display("FAIL b2b_second: got %h flags %b lat %0d busy %0d, required %h flags %b lat 27 busy 26", ifc.result, flags_now(), c, b, e.res, e.flags);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_truncation();
    test_sign_and_norm();
    test_specials();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
